// File: rtl/isp_conv_pkg.sv
// Shared helpers for the ISP mask/demosaic stages: width math and output limiting.
package isp_conv_pkg;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = 32'(i + 1);
        end
        return r;
    endfunction

    // Accumulator width that cannot overflow for ntap signed products.
    function automatic int unsigned acc_w(input int unsigned dw, input int unsigned cw,
                                          input int unsigned ntap);
        return dw + cw + 1 + clog2(ntap);
    endfunction

    // Negative handling (clamp to 0 or absolute value), then saturate to dw bits.
    function automatic logic [63:0] sat_clamp(input logic signed [63:0] v, input logic abs_en,
                                              input int unsigned dw);
        logic signed [63:0] a;
        logic signed [63:0] lim;
        lim = (64'sd1 <<< dw) - 64'sd1;
        if (v < 64'sd0) a = abs_en ? -v : 64'sd0;
        else            a = v;
        if (a > lim) a = lim;
        return a;
    endfunction

endpackage

// File: rtl/conv_add_tree.sv
// Registered two-level signed reduction: groups of four (S2), then final sum (S3).
module conv_add_tree #(
    parameter int unsigned N  = 13,
    parameter int unsigned W  = 19,
    parameter int unsigned OW = 23
) (
    input  logic                 isp_clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [N*W-1:0]       terms,
    output logic signed [OW-1:0] sum
);

    localparam int unsigned NG = (N + 3) / 4;

    logic [NG*4*W-1:0]   padded;
    logic signed [OW-1:0] part_c [NG];
    logic signed [OW-1:0] part_q [NG];
    logic signed [OW-1:0] total_c;

    // Zero-padding to a multiple of four keeps every group select in range.
    assign padded = (NG*4*W)'(terms);

    always_comb begin
        for (int g = 0; g < NG; g++) begin
            part_c[g] = '0;
            for (int j = 0; j < 4; j++) begin
                part_c[g] = part_c[g] + OW'($signed(padded[(g*4+j)*W +: W]));
            end
        end
    end

    always_comb begin
        total_c = '0;
        for (int g = 0; g < NG; g++) total_c = total_c + part_q[g];
    end

    always_ff @(posedge isp_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < NG; g++) part_q[g] <= '0;
            sum <= '0;
        end else if (en) begin
            for (int g = 0; g < NG; g++) part_q[g] <= part_c[g];
            sum <= total_c;
        end
    end

endmodule

// File: rtl/conv_mask_wsum_n.sv
// N-tap weighted-sum mask stage: runtime signed coefficients, frame-aligned cfg swap,
// 4-stage pipeline with back-pressure, clamp-or-abs output with saturation.
module conv_mask_wsum_n
    import isp_conv_pkg::*;
#(
    parameter int unsigned DW   = 12,
    parameter int unsigned TW   = 4,
    parameter int unsigned NTAP = 13,
    parameter int unsigned CW   = 6,
    parameter bit          RND  = 1'b1
) (
    input  logic                   isp_clk,
    input  logic                   rst_n,
    input  logic                   din_vld,
    output logic                   din_rdy,
    input  logic                   din_sof,
    input  logic [NTAP*(DW+TW)-1:0] din_pix,
    input  logic                   cfg_load,
    input  logic [NTAP*CW-1:0]     cfg_coef,
    input  logic [3:0]             cfg_shift,
    input  logic                   cfg_abs,
    output logic                   dout_vld,
    input  logic                   dout_rdy,
    output logic [DW+TW-1:0]       Dout
);

    localparam int unsigned WW   = DW + TW;
    localparam int unsigned PW   = DW + CW + 1;
    localparam int unsigned ACCW = acc_w(DW, CW, NTAP);
    localparam int unsigned RW   = ACCW + 1;

    logic en, accept, sof_acc;

    logic [NTAP*CW-1:0] sh_coef, ac_coef, coef_sel_c;
    logic [3:0]         sh_shift, ac_shift, shift_sel_c;
    logic               sh_abs, ac_abs, abs_sel_c;

    logic signed [PW-1:0] pix_ext, coef_ext;
    logic [NTAP*PW-1:0]   prod_c, prod_q;

    logic          vld1, vld2, vld3;
    logic [TW-1:0] tag1, tag2, tag3;
    logic [3:0]    shift1, shift2, shift3;
    logic          abs1, abs2, abs3;

    logic signed [ACCW-1:0] sum3;
    logic signed [RW-1:0]   rnd_c, rsum_c, v_c;
    logic [DW-1:0]          res_c;
    logic                   unused_pix;

    assign en      = dout_rdy | ~dout_vld;
    assign din_rdy = en;
    assign accept  = din_vld & en;
    assign sof_acc = accept & din_sof;

    // Only tap-0 tag travels; the other taps' tags are intentionally dropped.
    assign unused_pix = ^din_pix;

    // The SOF window already sees the set it is promoting into active.
    assign coef_sel_c  = sof_acc ? sh_coef  : ac_coef;
    assign shift_sel_c = sof_acc ? sh_shift : ac_shift;
    assign abs_sel_c   = sof_acc ? sh_abs   : ac_abs;

    always_ff @(posedge isp_clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_coef  <= '0;
            sh_shift <= '0;
            sh_abs   <= 1'b0;
            ac_coef  <= '0;
            ac_shift <= '0;
            ac_abs   <= 1'b0;
        end else begin
            if (cfg_load) begin
                sh_coef  <= cfg_coef;
                sh_shift <= cfg_shift;
                sh_abs   <= cfg_abs;
            end
            if (sof_acc) begin
                ac_coef  <= sh_coef;
                ac_shift <= sh_shift;
                ac_abs   <= sh_abs;
            end
        end
    end

    // S1 multipliers: unsigned pixel against signed coefficient.
    always_comb begin
        prod_c   = '0;
        pix_ext  = '0;
        coef_ext = '0;
        for (int k = 0; k < NTAP; k++) begin
            pix_ext  = PW'($signed({1'b0, din_pix[k*WW+TW +: DW]}));
            coef_ext = PW'($signed(coef_sel_c[k*CW +: CW]));
            prod_c[k*PW +: PW] = pix_ext * coef_ext;
        end
    end

    always_ff @(posedge isp_clk or negedge rst_n) begin
        if (!rst_n) begin
            vld1   <= 1'b0;
            prod_q <= '0;
            tag1   <= '0;
            shift1 <= '0;
            abs1   <= 1'b0;
            vld2   <= 1'b0;
            tag2   <= '0;
            shift2 <= '0;
            abs2   <= 1'b0;
            vld3   <= 1'b0;
            tag3   <= '0;
            shift3 <= '0;
            abs3   <= 1'b0;
        end else if (en) begin
            vld1 <= accept;
            if (accept) begin
                prod_q <= prod_c;
                tag1   <= din_pix[TW-1:0];
                shift1 <= shift_sel_c;
                abs1   <= abs_sel_c;
            end
            vld2   <= vld1;
            tag2   <= tag1;
            shift2 <= shift1;
            abs2   <= abs1;
            vld3   <= vld2;
            tag3   <= tag2;
            shift3 <= shift2;
            abs3   <= abs2;
        end
    end

    conv_add_tree #(
        .N  (NTAP),
        .W  (PW),
        .OW (ACCW)
    ) u_tree (
        .isp_clk (isp_clk),
        .rst_n   (rst_n),
        .en      (en),
        .terms   (prod_q),
        .sum     (sum3)
    );

    // S4: optional round-half-up, arithmetic shift, then clamp/abs and saturate.
    always_comb begin
        rnd_c = '0;
        if (RND && (shift3 != 4'd0)) rnd_c = RW'(1) << (shift3 - 4'd1);
        rsum_c = RW'(sum3) + rnd_c;
        v_c    = rsum_c >>> shift3;
        res_c  = DW'(sat_clamp(64'(v_c), abs3, DW));
    end

    always_ff @(posedge isp_clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_vld <= 1'b0;
            Dout     <= '0;
        end else if (en) begin
            dout_vld <= vld3;
            if (vld3) Dout <= {res_c, tag3};
        end
    end

endmodule

// File: tb/tb_conv_mask_wsum_n.sv
// Directed bench for conv_mask_wsum_n: identity, clamp/abs, saturation, rounding,
// back-pressure streaming, frame-aligned cfg swap and async reset with words in flight.
module tb_conv_mask_wsum_n;

    localparam int unsigned DW   = 12;
    localparam int unsigned TW   = 4;
    localparam int unsigned NTAP = 13;
    localparam int unsigned CW   = 6;
    localparam int unsigned WW   = DW + TW;

    logic                   isp_clk = 1'b0;
    logic                   rst_n;
    logic                   din_vld, din_sof, cfg_load, cfg_abs, dout_rdy;
    logic [NTAP*WW-1:0]     din_pix;
    logic [NTAP*CW-1:0]     cfg_coef;
    logic [3:0]             cfg_shift;
    logic                   din_rdy, dout_vld;
    logic [WW-1:0]          Dout;
    logic                   din_rdy_t, dout_vld_t;
    logic [WW-1:0]          dout_t;

    logic [DW-1:0]          pdat  [NTAP];
    logic [TW-1:0]          ptag  [NTAP];
    logic signed [CW-1:0]   pcoef [NTAP];

    int n_vec = 0;
    int n_err = 0;

    conv_mask_wsum_n #(.DW(DW), .TW(TW), .NTAP(NTAP), .CW(CW), .RND(1'b1)) u_dut (
        .isp_clk (isp_clk), .rst_n (rst_n), .din_vld (din_vld), .din_rdy (din_rdy),
        .din_sof (din_sof), .din_pix (din_pix), .cfg_load (cfg_load), .cfg_coef (cfg_coef),
        .cfg_shift (cfg_shift), .cfg_abs (cfg_abs), .dout_vld (dout_vld),
        .dout_rdy (dout_rdy), .Dout (Dout)
    );

    conv_mask_wsum_n #(.DW(DW), .TW(TW), .NTAP(NTAP), .CW(CW), .RND(1'b0)) u_dut_t (
        .isp_clk (isp_clk), .rst_n (rst_n), .din_vld (din_vld), .din_rdy (din_rdy_t),
        .din_sof (din_sof), .din_pix (din_pix), .cfg_load (cfg_load), .cfg_coef (cfg_coef),
        .cfg_shift (cfg_shift), .cfg_abs (cfg_abs), .dout_vld (dout_vld_t),
        .dout_rdy (dout_rdy), .Dout (dout_t)
    );

    always #5 isp_clk = ~isp_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge isp_clk);
        #1;
    endtask

    task automatic clear_vectors;
        for (int k = 0; k < NTAP; k++) begin
            pdat[k]  = '0;
            ptag[k]  = '0;
            pcoef[k] = '0;
        end
    endtask

    task automatic drive_pix;
        for (int k = 0; k < NTAP; k++) din_pix[k*WW +: WW] = {pdat[k], ptag[k]};
    endtask

    task automatic drive_cfg(input logic [3:0] sh, input logic ab);
        for (int k = 0; k < NTAP; k++) cfg_coef[k*CW +: CW] = pcoef[k];
        cfg_shift = sh;
        cfg_abs   = ab;
    endtask

    task automatic load_cfg(input logic [3:0] sh, input logic ab);
        drive_cfg(sh, ab);
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
    endtask

    // One window in, then sample one cycle early and at the nominal 4-cycle latency.
    task automatic window(input logic sof, input logic ld, output logic [WW-1:0] res,
                          output logic [WW-1:0] res_t, output logic early, output logic vld);
        drive_pix();
        din_vld  = 1'b1;
        din_sof  = sof;
        cfg_load = ld;
        step();
        din_vld  = 1'b0;
        din_sof  = 1'b0;
        cfg_load = 1'b0;
        step();
        step();
        early = dout_vld;
        step();
        vld   = dout_vld;
        res   = Dout;
        res_t = dout_t;
    endtask

    task automatic test_reset;
        n_vec++; if (dout_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got %b want 0", dout_vld); end
        n_vec++; if (Dout !== '0) begin n_err++; $display("FAIL reset_dout got %h want 0000", Dout); end
        n_vec++; if (din_rdy !== 1'b1) begin n_err++; $display("FAIL reset_rdy got %b want 1", din_rdy); end
    endtask

    task automatic test_identity;
        logic [WW-1:0] r, rt;
        logic e, v;
        clear_vectors();
        pcoef[0] = 6'sd8;
        for (int k = 1; k < NTAP; k++) begin pdat[k] = 12'h555; ptag[k] = 4'h5; end
        load_cfg(4'd3, 1'b0);
        pdat[0] = 12'h123;
        ptag[0] = 4'hA;
        window(1'b1, 1'b0, r, rt, e, v);
        n_vec++; if (e !== 1'b0) begin n_err++; $display("FAIL ident_latency_early got %b want 0", e); end
        n_vec++; if (v !== 1'b1) begin n_err++; $display("FAIL ident_vld got %b want 1", v); end
        n_vec++; if (r !== 16'h123A) begin n_err++; $display("FAIL ident_dout got %h want 123a", r); end
    endtask

    task automatic test_clamp_abs;
        logic [WW-1:0] r, rt;
        logic e, v;
        clear_vectors();
        pcoef[0] = -6'sd8;
        pdat[0]  = 12'h100;
        ptag[0]  = 4'h3;
        load_cfg(4'd3, 1'b0);
        window(1'b1, 1'b0, r, rt, e, v);
        n_vec++; if (r !== 16'h0003) begin n_err++; $display("FAIL clamp_neg got %h want 0003", r); end
        load_cfg(4'd3, 1'b1);
        window(1'b1, 1'b0, r, rt, e, v);
        n_vec++; if (r !== 16'h1003) begin n_err++; $display("FAIL abs_neg got %h want 1003", r); end
    endtask

    task automatic test_saturation;
        logic [WW-1:0] r, rt;
        logic e, v;
        clear_vectors();
        for (int k = 0; k < NTAP; k++) begin pcoef[k] = 6'sd31; pdat[k] = 12'hFFF; end
        ptag[0] = 4'hC;
        load_cfg(4'd3, 1'b0);
        window(1'b1, 1'b0, r, rt, e, v);
        n_vec++; if (r !== 16'hFFFC) begin n_err++; $display("FAIL sat_pos got %h want fffc", r); end
        for (int k = 0; k < NTAP; k++) pcoef[k] = 6'b100000;
        load_cfg(4'd3, 1'b1);
        window(1'b1, 1'b0, r, rt, e, v);
        n_vec++; if (r !== 16'hFFFC) begin n_err++; $display("FAIL sat_abs got %h want fffc", r); end
        load_cfg(4'd3, 1'b0);
        window(1'b1, 1'b0, r, rt, e, v);
        n_vec++; if (r !== 16'h000C) begin n_err++; $display("FAIL sat_clamp0 got %h want 000c", r); end
    endtask

    task automatic test_rounding;
        logic [WW-1:0] r, rt;
        logic e, v;
        clear_vectors();
        pcoef[0] = 6'sd1;
        pdat[0]  = 12'd4;
        load_cfg(4'd3, 1'b0);
        window(1'b1, 1'b0, r, rt, e, v);
        n_vec++; if (r !== 16'h0010) begin n_err++; $display("FAIL round_rnd1 got %h want 0010", r); end
        n_vec++; if (rt !== 16'h0000) begin n_err++; $display("FAIL round_rnd0 got %h want 0000", rt); end
        load_cfg(4'd0, 1'b0);
        window(1'b1, 1'b0, r, rt, e, v);
        n_vec++; if (r !== 16'h0040) begin n_err++; $display("FAIL round_shift0 got %h want 0040", r); end
        n_vec++; if (rt !== 16'h0040) begin n_err++; $display("FAIL trunc_shift0 got %h want 0040", rt); end
    endtask

    task automatic test_back_to_back;
        logic [WW-1:0] q[$];
        logic [WW-1:0] exp_w, prev_dout;
        logic          prev_stall;
        int            sent, got;
        clear_vectors();
        pcoef[0] = 6'sd8;
        load_cfg(4'd3, 1'b0);
        sent = 0;
        got = 0;
        prev_stall = 1'b0;
        prev_dout = '0;
        for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
            dout_rdy = !(cyc >= 8 && cyc < 13);
            if (sent < 20) begin
                pdat[0] = 12'h100 + 12'(sent * 13);
                ptag[0] = 4'(sent);
                drive_pix();
                din_vld = 1'b1;
                din_sof = (sent == 0);
            end else begin
                din_vld = 1'b0;
                din_sof = 1'b0;
            end
            #1;
            if (dout_vld && dout_rdy) begin
                exp_w = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
                n_vec++;
                if (Dout !== exp_w) begin n_err++; $display("FAIL stream_word%0d got %h want %h", got, Dout, exp_w); end
                got++;
            end
            if (dout_vld && !dout_rdy) begin
                n_vec++;
                if (din_rdy !== 1'b0) begin n_err++; $display("FAIL stall_rdy cyc%0d got %b want 0", cyc, din_rdy); end
                if (prev_stall) begin
                    n_vec++;
                    if (Dout !== prev_dout) begin n_err++; $display("FAIL stall_hold cyc%0d got %h want %h", cyc, Dout, prev_dout); end
                end
            end
            prev_stall = dout_vld && !dout_rdy;
            prev_dout  = Dout;
            if (din_vld && din_rdy) begin
                q.push_back({pdat[0], ptag[0]});
                sent++;
            end
            @(posedge isp_clk);
            #1;
        end
        din_vld  = 1'b0;
        din_sof  = 1'b0;
        dout_rdy = 1'b1;
        n_vec++; if (got != 20) begin n_err++; $display("FAIL stream_count got %0d want 20", got); end
        n_vec++; if (q.size() != 0) begin n_err++; $display("FAIL stream_leftover got %0d want 0", q.size()); end
    endtask

    task automatic test_cfg_swap;
        logic [WW-1:0] r, rt;
        logic e, v;
        clear_vectors();
        pdat[0] = 12'h040;
        ptag[0] = 4'h1;
        pcoef[0] = 6'sd8;
        load_cfg(4'd3, 1'b0);
        window(1'b1, 1'b0, r, rt, e, v);
        n_vec++; if (r !== 16'h0401) begin n_err++; $display("FAIL swap_setA got %h want 0401", r); end
        pcoef[0] = 6'sd16;
        load_cfg(4'd3, 1'b0);
        window(1'b0, 1'b0, r, rt, e, v);
        n_vec++; if (r !== 16'h0401) begin n_err++; $display("FAIL swap_midframe got %h want 0401", r); end
        pcoef[0] = 6'sd24;
        drive_cfg(4'd3, 1'b0);
        window(1'b1, 1'b1, r, rt, e, v);
        n_vec++; if (r !== 16'h0801) begin n_err++; $display("FAIL swap_sof_B got %h want 0801", r); end
        window(1'b0, 1'b0, r, rt, e, v);
        n_vec++; if (r !== 16'h0801) begin n_err++; $display("FAIL swap_frame_B got %h want 0801", r); end
        window(1'b1, 1'b0, r, rt, e, v);
        n_vec++; if (r !== 16'h0C01) begin n_err++; $display("FAIL swap_sof_C got %h want 0c01", r); end
        pcoef[0] = 6'sd31;
        load_cfg(4'd3, 1'b0);
        din_sof = 1'b1;
        step();
        din_sof = 1'b0;
        window(1'b0, 1'b0, r, rt, e, v);
        n_vec++; if (r !== 16'h0C01) begin n_err++; $display("FAIL swap_sof_noaccept got %h want 0c01", r); end
    endtask

    task automatic test_reset_inflight;
        logic [WW-1:0] r, rt;
        logic e, v;
        clear_vectors();
        pcoef[0] = 6'sd8;
        load_cfg(4'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            pdat[0] = 12'h200 + 12'(i);
            ptag[0] = 4'(i + 2);
            drive_pix();
            din_vld = 1'b1;
            din_sof = (i == 0);
            step();
        end
        din_vld = 1'b0;
        din_sof = 1'b0;
        n_vec++; if (dout_vld !== 1'b1) begin n_err++; $display("FAIL inflight_pre_vld got %b want 1", dout_vld); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (dout_vld !== 1'b0) begin n_err++; $display("FAIL async_rst_vld got %b want 0", dout_vld); end
        n_vec++; if (Dout !== '0) begin n_err++; $display("FAIL async_rst_dout got %h want 0000", Dout); end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++; if (dout_vld !== 1'b0) begin n_err++; $display("FAIL post_rst_idle%0d got %b want 0", i, dout_vld); end
        end
        pdat[0] = 12'h123;
        ptag[0] = 4'h6;
        window(1'b1, 1'b0, r, rt, e, v);
        n_vec++; if (v !== 1'b1 || r !== 16'h0006) begin n_err++; $display("FAIL post_rst_zero_cfg got %b/%h want 1/0006", v, r); end
        load_cfg(4'd3, 1'b0);
        window(1'b1, 1'b0, r, rt, e, v);
        n_vec++; if (r !== 16'h1236) begin n_err++; $display("FAIL post_rst_reload got %h want 1236", r); end
    endtask

    initial begin
        rst_n     = 1'b0;
        din_vld   = 1'b0;
        din_sof   = 1'b0;
        din_pix   = '0;
        cfg_load  = 1'b0;
        cfg_coef  = '0;
        cfg_shift = '0;
        cfg_abs   = 1'b0;
        dout_rdy  = 1'b1;
        clear_vectors();
        step();
        step();
        rst_n = 1'b1;
        step();
        test_reset();
        test_identity();
        test_clamp_abs();
        test_saturation();
        test_rounding();
        test_back_to_back();
        test_cfg_swap();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
